// File: rtl/multi_channel_debouncer.sv
// N-channel debouncer: 2-flop sync, per-channel counter, press/release pulses.
// Optional long-press detection enabled by MULTI_DEBOUNCE_LONG_PRESS_EN.
module multi_channel_debouncer #(
  parameter int CHANNELS      = 4,
  parameter int CLK_FREQUENCY = 40_000_000,
  parameter int DEBOUNCE_HZ   = 2,
  parameter int LONG_COUNT    = 3 * (CLK_FREQUENCY / DEBOUNCE_HZ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in_buttons,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                any_press,
  output logic [CHANNELS-1:0] long_pulse
);

  localparam int COUNT_VALUE = CLK_FREQUENCY / DEBOUNCE_HZ;
  localparam int CNT_W       = $clog2(COUNT_VALUE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT_VALUE - 1);

  logic [CHANNELS-1:0] sync0_q;
  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] press_q;
  logic [CHANNELS-1:0] press_d;
  logic [CHANNELS-1:0] release_q;
  logic [CHANNELS-1:0] release_d;
  logic                any_q;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  // Count consecutive cycles where sync1 disagrees with the held level
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync1_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i]   = sync1_q[i];
        press_d[i]   = sync1_q[i];
        release_d[i] = ~sync1_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counters, level and registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_q   <= '0;
      sync1_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      sync0_q   <= in_buttons;
      sync1_q   <= sync0_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= |press_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign any_press     = any_q;

`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
  localparam int HCNT_W = $clog2(LONG_COUNT + 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(LONG_COUNT);
  localparam logic [HCNT_W-1:0] HCNT_PRE = HCNT_W'(LONG_COUNT - 1);

  logic [HCNT_W-1:0]   hcnt_q [CHANNELS];
  logic [HCNT_W-1:0]   hcnt_d [CHANNELS];
  logic [CHANNELS-1:0] long_q;
  logic [CHANNELS-1:0] long_d;

  // Saturating hold counter; fires once when it reaches LONG_COUNT
  always_comb begin
    long_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hcnt_d[i] = hcnt_q[i];
      if (!level_q[i]) begin
        hcnt_d[i] = '0;
      end else if (hcnt_q[i] != HCNT_MAX) begin
        hcnt_d[i] = hcnt_q[i] + HCNT_W'(1);
        long_d[i] = (hcnt_q[i] == HCNT_PRE);
      end
    end
  end

  // Hold counters and registered long-press pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      long_q <= '0;
      for (int i = 0; i < CHANNELS; i++) hcnt_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int i = 0; i < CHANNELS; i++) hcnt_q[i] <= hcnt_d[i];
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = '0;
`endif

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Self-checking bench for multi_channel_debouncer with a window-based model.
// Long-press checks follow MULTI_DEBOUNCE_LONG_PRESS_EN.
module tb_multi_channel_debouncer;

  localparam int CH = 4;
  localparam int CV = 10;
  localparam int LC = 30;
`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
  localparam int LONG_ON = 1;
`else
  localparam int LONG_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] in_buttons = '0;
  logic [CH-1:0] level;
  logic [CH-1:0] press_pulse;
  logic [CH-1:0] release_pulse;
  logic          any_press;
  logic [CH-1:0] long_pulse;

  multi_channel_debouncer #(
    .CHANNELS(CH),
    .CLK_FREQUENCY(100),
    .DEBOUNCE_HZ(10),
    .LONG_COUNT(LC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_buttons(in_buttons),
    .level(level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .any_press(any_press),
    .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference: a change is taken when the last CV synchronised samples
  // all disagree with the held level.
  logic [CH-1:0] m_s0 = '0, m_s1 = '0, m_level = '0;
  logic [CH-1:0] m_press = '0, m_rel = '0, m_long = '0;
  logic          m_any = 1'b0;
  logic          m_win [CH][CV];
  bit            m_armed [CH];
  int            m_pedge [CH];

  task automatic step();
    bit diff;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < CH; i++) begin
      if (reset) begin
        m_s0[i] = 0; m_s1[i] = 0; m_level[i] = 0;
        m_press[i] = 0; m_rel[i] = 0; m_long[i] = 0;
        m_armed[i] = 0;
        for (int j = 0; j < CV; j++) m_win[i][j] = 0;
      end else begin
        diff = 1;
        for (int j = 0; j < CV; j++)
          if (m_win[i][j] == m_level[i]) diff = 0;
        m_press[i] = diff && !m_level[i];
        m_rel[i]   = diff && m_level[i];
        m_long[i]  = (LONG_ON != 0) && m_armed[i] &&
                     (cyc == m_pedge[i] + LC);
        if (diff) m_level[i] = !m_level[i];
        if (m_press[i]) begin m_armed[i] = 1; m_pedge[i] = cyc; end
        if (m_rel[i]) m_armed[i] = 0;
        m_s1[i] = m_s0[i];
        m_s0[i] = in_buttons[i];
        for (int j = 0; j < CV - 1; j++) m_win[i][j] = m_win[i][j+1];
        m_win[i][CV-1] = m_s1[i];
      end
    end
    m_any = |m_press;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_buttons = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if ({level, press_pulse, release_pulse, any_press, long_pulse} !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got %h want 0", cyc,
                 {level, press_pulse, release_pulse, any_press, long_pulse});
      end
    end
    reset = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      step();
      checks++;
      if ({level, press_pulse, release_pulse, any_press, long_pulse} !==
          {m_level, m_press, m_rel, m_any, m_long}) begin
        errors++;
        $display("FAIL reset_model cyc=%0d got %h want %h", cyc,
                 {level, press_pulse, release_pulse, any_press, long_pulse},
                 {m_level, m_press, m_rel, m_any, m_long});
      end
      if (n == 12) begin
        checks++;
        if ({press_pulse, any_press, level} !== 9'b1111_1_1111) begin
          errors++;
          $display("FAIL reset_edge12 got %b want 111111111",
                   {press_pulse, any_press, level});
        end
      end
    end
  endtask

  task automatic test_clean_press();
    int seen;
    in_buttons = '0;
    for (int n = 0; n < 15; n++) step();
    for (int ph = 0; ph < 2; ph++) begin
      seen = 0;
      in_buttons[0] = (ph == 0);
      for (int n = 1; n <= 15; n++) begin
        step();
        checks++;
        if ({level, press_pulse, release_pulse, any_press, long_pulse} !==
            {m_level, m_press, m_rel, m_any, m_long}) begin
          errors++;
          $display("FAIL clean_model cyc=%0d got %h want %h", cyc,
                   {level, press_pulse, release_pulse, any_press, long_pulse},
                   {m_level, m_press, m_rel, m_any, m_long});
        end
        if ((ph == 0 ? press_pulse : release_pulse) == 4'b0001) seen = n;
      end
      checks++;
      if (seen != 12 || level !== {3'b000, ph == 0}) begin
        errors++;
        $display("FAIL clean_timing ph=%0d pulse_at=%0d want 12 level=%b",
                 ph, seen, level);
      end
    end
  endtask

  task automatic test_bounce();
    int presses, last_at;
    presses = 0;
    last_at = 0;
    for (int n = 0; n < 40; n++) begin
      in_buttons[1] = ((n / 4) % 2) == 0;
      step();
      if (press_pulse[1] || release_pulse[1]) presses += 100;
    end
    in_buttons[1] = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      step();
      checks++;
      if ({level, press_pulse, release_pulse, any_press, long_pulse} !==
          {m_level, m_press, m_rel, m_any, m_long}) begin
        errors++;
        $display("FAIL bounce_model cyc=%0d got %h want %h", cyc,
                 {level, press_pulse, release_pulse, any_press, long_pulse},
                 {m_level, m_press, m_rel, m_any, m_long});
      end
      if (press_pulse[1]) begin presses++; last_at = n; end
    end
    checks++;
    if (presses != 1 || last_at != 12) begin
      errors++;
      $display("FAIL bounce_press count=%0d at=%0d want 1 at 12",
               presses, last_at);
    end
  endtask

  task automatic test_simultaneous();
    int both, anys, rels;
    both = 0; anys = 0; rels = 0;
    in_buttons[3:2] = 2'b11;
    for (int n = 0; n < 15; n++) begin
      step();
      if (press_pulse === 4'b1100) both++;
      if (any_press) anys++;
    end
    checks++;
    if (both != 1 || anys != 1) begin
      errors++;
      $display("FAIL simul_press both=%0d any=%0d want 1 1", both, anys);
    end
    in_buttons[3] = 1'b0;
    for (int n = 0; n < 9; n++) step();
    in_buttons[3] = 1'b1;
    for (int n = 0; n < 15; n++) begin
      step();
      checks++;
      if ({level, press_pulse, release_pulse, any_press, long_pulse} !==
          {m_level, m_press, m_rel, m_any, m_long}) begin
        errors++;
        $display("FAIL glitch_model cyc=%0d got %h want %h", cyc,
                 {level, press_pulse, release_pulse, any_press, long_pulse},
                 {m_level, m_press, m_rel, m_any, m_long});
      end
      if (release_pulse[3] || !level[3]) rels++;
    end
    checks++;
    if (rels != 0) begin
      errors++;
      $display("FAIL glitch_ch3 changes=%0d want 0", rels);
    end
  endtask

  task automatic test_reset_midcount();
    int at;
    at = 0;
    in_buttons[0] = 1'b1;
    for (int n = 0; n < 9; n++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      step();
      checks++;
      if ({level, press_pulse, release_pulse, any_press, long_pulse} !==
          {m_level, m_press, m_rel, m_any, m_long}) begin
        errors++;
        $display("FAIL midrst_model cyc=%0d got %h want %h", cyc,
                 {level, press_pulse, release_pulse, any_press, long_pulse},
                 {m_level, m_press, m_rel, m_any, m_long});
      end
      if (press_pulse[0]) at = n;
    end
    checks++;
    if (at != 12) begin
      errors++;
      $display("FAIL midrst_press at=%0d want 12", at);
    end
  endtask

  task automatic test_long_press();
    int longs, pcyc, lcyc;
    for (int r = 0; r < 2; r++) begin
      longs = 0; pcyc = 0; lcyc = 0;
      in_buttons[0] = 1'b0;
      for (int n = 0; n < 15; n++) step();
      in_buttons[0] = 1'b1;
      for (int n = 0; n < 90; n++) begin
        step();
        checks++;
        if ({level, press_pulse, release_pulse, any_press, long_pulse} !==
            {m_level, m_press, m_rel, m_any, m_long}) begin
          errors++;
          $display("FAIL long_model cyc=%0d got %h want %h", cyc,
                   {level, press_pulse, release_pulse, any_press, long_pulse},
                   {m_level, m_press, m_rel, m_any, m_long});
        end
        if (press_pulse[0]) pcyc = cyc;
        if (long_pulse[0]) begin longs++; lcyc = cyc; end
      end
      checks++;
      if (longs != LONG_ON || (LONG_ON != 0 && lcyc - pcyc != LC)) begin
        errors++;
        $display("FAIL long_count r=%0d n=%0d dist=%0d want %0d dist %0d",
                 r, longs, lcyc - pcyc, LONG_ON, LC);
      end
    end
  endtask

  task automatic test_random();
    int hold [CH];
    for (int i = 0; i < CH; i++) hold[i] = 0;
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < CH; i++) begin
        if (hold[i] == 0) begin
          in_buttons[i] = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 24));
        end
        hold[i]--;
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
      checks++;
      if ({level, press_pulse, release_pulse, any_press, long_pulse} !==
          {m_level, m_press, m_rel, m_any, m_long}) begin
        errors++;
        $display("FAIL random_model cyc=%0d got %h want %h", cyc,
                 {level, press_pulse, release_pulse, any_press, long_pulse},
                 {m_level, m_press, m_rel, m_any, m_long});
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_midcount();
    test_long_press();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
